// File: rtl/eth_pkg.sv
// Shared types and constants for the RMII receive frame controller.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    PASS,
    DISCARD,
    WAIT_CRC,
    DONE
  } rx_state_t;

  localparam logic [47:0] BCAST_MAC       = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned DIBITS_PER_BYTE = 4;
  localparam int unsigned MAC_DIBITS      = 24;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised saturating up-counter with increment enable.
// Only compiled when RX_STATS_EN is defined (statistics build).
`ifdef RX_STATS_EN
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) count_d = count_q + WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/rx_frame_ctrl.sv
// Per-frame RMII receive sequencer: dest-MAC filter, length/alignment checks,
// CRC verdict wait, one commit/drop pulse per frame. Statistics under RX_STATS_EN.
module rx_frame_ctrl
  import eth_pkg::*;
#(
  parameter logic [47:0] MY_MAC      = 48'h69_69_5A_06_54_91,
  parameter int unsigned MIN_BYTES   = 64,
  parameter int unsigned CRC_TIMEOUT = 8,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             axiiv,
  input  logic [1:0]       axiid,
  input  logic             crc_done,
  input  logic             crc_ok,
  output logic             axiov,
  output logic [1:0]       axiod,
  output logic             commit,
  output logic             drop,
  output logic             busy,
  output logic [CNT_W-1:0] frame_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int unsigned TMR_W   = $clog2(CRC_TIMEOUT + 1);
  localparam logic [12:0] CNT_MAX = '1;

  rx_state_t        state_q, state_d;
  logic             prev_valid_q;
  logic [12:0]      cnt_q, cnt_d, cnt_inc, byte_len;
  logic             aligned;
  // Top dibit of the address is never stored: the compare uses the live dibit.
  logic [45:0]      dest_q, dest_d;
  logic [47:0]      dest_full;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             axiov_q, axiov_d;
  logic [1:0]       axiod_q, axiod_d;
  logic             commit_q, commit_d;
  logic             drop_q, drop_d;

  always_comb begin
    dest_full = {dest_q, axiid};
    cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 13'd1;
    byte_len  = cnt_q / 13'(DIBITS_PER_BYTE);
    aligned   = (cnt_q % 13'(DIBITS_PER_BYTE)) == '0;

    state_d  = state_q;
    cnt_d    = cnt_q;
    dest_d   = dest_q;
    tmr_d    = tmr_q;
    axiov_d  = 1'b0;
    axiod_d  = axiod_q;
    commit_d = 1'b0;
    drop_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (axiiv && !prev_valid_q) begin
          state_d = HDR;
          cnt_d   = 13'd1;
          dest_d  = dest_full[45:0];
          axiov_d = 1'b1;
          axiod_d = axiid;
        end
      end
      HDR: begin
        if (axiiv) begin
          cnt_d   = cnt_inc;
          dest_d  = dest_full[45:0];
          axiov_d = 1'b1;
          axiod_d = axiid;
          if (cnt_q == 13'(MAC_DIBITS - 1))
            state_d = (dest_full == MY_MAC || dest_full == BCAST_MAC) ? PASS : DISCARD;
        end else begin
          state_d = DONE;
          drop_d  = 1'b1;
        end
      end
      PASS: begin
        if (axiiv) begin
          cnt_d   = cnt_inc;
          axiov_d = 1'b1;
          axiod_d = axiid;
        end else if (!aligned || byte_len < 13'(MIN_BYTES)) begin
          state_d = DONE;
          drop_d  = 1'b1;
        end else begin
          state_d = WAIT_CRC;
          tmr_d   = '0;
        end
      end
      DISCARD: begin
        if (axiiv) begin
          cnt_d = cnt_inc;
        end else begin
          state_d = DONE;
          drop_d  = 1'b1;
        end
      end
      WAIT_CRC: begin
        if (crc_done) begin
          state_d  = DONE;
          commit_d = crc_ok;
          drop_d   = !crc_ok;
        end else if (tmr_q == TMR_W'(CRC_TIMEOUT - 1)) begin
          state_d = DONE;
          drop_d  = 1'b1;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // prev_valid resets high so a frame already running at reset is skipped whole.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      prev_valid_q <= 1'b1;
      cnt_q        <= '0;
      dest_q       <= '0;
      tmr_q        <= '0;
      axiov_q      <= 1'b0;
      axiod_q      <= '0;
      commit_q     <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_valid_q <= axiiv;
      cnt_q        <= cnt_d;
      dest_q       <= dest_d;
      tmr_q        <= tmr_d;
      axiov_q      <= axiov_d;
      axiod_q      <= axiod_d;
      commit_q     <= commit_d;
      drop_q       <= drop_d;
    end
  end

  assign axiov  = axiov_q;
  assign axiod  = axiod_q;
  assign commit = commit_q;
  assign drop   = drop_q;
  assign busy   = (state_q != IDLE);

`ifdef RX_STATS_EN
  sat_counter #(.WIDTH(CNT_W)) u_frame_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (commit_q),
    .count (frame_count)
  );

  sat_counter #(.WIDTH(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_q),
    .count (drop_count)
  );
`else
  assign frame_count = '0;
  assign drop_count  = '0;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Bench for rx_frame_ctrl: table of frames plus reset and saturation sequences,
// with scoreboard queues for forwarded dibits and commit/drop pulses.
module tb_rx_frame_ctrl;

  localparam int unsigned CNT_W   = 4;
  localparam int unsigned CNT_SAT = (1 << CNT_W) - 1;
  localparam logic [47:0] MY_MAC  = 48'h69_69_5A_06_54_91;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;
  localparam logic [1:0]  K_COMMIT = 2'b01;
  localparam logic [1:0]  K_DROP   = 2'b10;

  logic             clk = 1'b0;
  logic             rst, axiiv, crc_done, crc_ok;
  logic [1:0]       axiid;
  logic             axiov, commit, drop, busy;
  logic [1:0]       axiod;
  logic [CNT_W-1:0] frame_count, drop_count;

  rx_frame_ctrl #(
    .MY_MAC      (MY_MAC),
    .MIN_BYTES   (64),
    .CRC_TIMEOUT (8),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .axiiv       (axiiv),
    .axiid       (axiid),
    .crc_done    (crc_done),
    .crc_ok      (crc_ok),
    .axiov       (axiov),
    .axiod       (axiod),
    .commit      (commit),
    .drop        (drop),
    .busy        (busy),
    .frame_count (frame_count),
    .drop_count  (drop_count)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [1:0] d; int at; } fwd_t;
  typedef struct { logic [1:0] kind; int at; } evt_t;
  typedef struct {
    logic [47:0] mac;
    int          ndib;
    int          crc_d;   // cycle after end carrying crc_done, 0 = never
    logic        crc_ok;
    int          fwd;     // dibits expected on axiov
    logic [1:0]  kind;
    int          lat;     // pulse cycle relative to the axiiv-low cycle
    int          junk;    // dibits of a follow-on frame started in cycle 1
  } frame_t;

  fwd_t fwd_q[$];
  evt_t evt_q[$];
  fwd_t mon_f;
  evt_t mon_e;
  int errors = 0;
  int checks = 0;
  int unsigned exp_fc = 0;
  int unsigned exp_dc = 0;
  frame_t vec[11];
  frame_t good;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic longint stat(input int unsigned v);
`ifdef RX_STATS_EN
    return longint'(v);
`else
    return (v == 0) ? 0 : 0;
`endif
  endfunction

  always @(negedge clk) begin
    if (axiov) begin
      if (fwd_q.size() == 0) chk("fwd_unexpected", 1, 0);
      else begin
        mon_f = fwd_q.pop_front();
        chk("fwd_data", axiod, mon_f.d);
        chk("fwd_cycle", cyc, mon_f.at);
      end
    end
    if (commit || drop) begin
      if (evt_q.size() == 0) chk("pulse_unexpected", {drop, commit}, 0);
      else begin
        mon_e = evt_q.pop_front();
        chk("pulse_kind", {drop, commit}, mon_e.kind);
        chk("pulse_cycle", cyc, mon_e.at);
      end
    end
  end

  task automatic settle_checks(input string tag);
    @(negedge clk);
    chk({tag, "_evt_pending"}, evt_q.size(), 0);
    chk({tag, "_fwd_pending"}, fwd_q.size(), 0);
    chk({tag, "_frame_count"}, frame_count, stat(exp_fc));
    chk({tag, "_drop_count"}, drop_count, stat(exp_dc));
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic run_frame(input frame_t f);
    int c0;
    logic [1:0] d;
    for (int i = 0; i < f.ndib; i++) begin
      @(posedge clk); #1;
      if (i < 24) d = f.mac[47-2*i -: 2];
      else        d = 2'($urandom);
      axiiv = 1'b1;
      axiid = d;
      if (i < f.fwd) fwd_q.push_back('{d, cyc + 1});
    end
    @(posedge clk); #1;
    axiiv = 1'b0;
    axiid = 2'b00;
    c0 = cyc;
    evt_q.push_back('{f.kind, c0 + f.lat});
    if (f.kind == K_COMMIT) exp_fc = (exp_fc == CNT_SAT) ? exp_fc : exp_fc + 1;
    else                    exp_dc = (exp_dc == CNT_SAT) ? exp_dc : exp_dc + 1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      crc_done = (c == f.crc_d);
      crc_ok   = (c == f.crc_d) ? f.crc_ok : 1'($urandom);
      axiiv    = (c <= f.junk);
      axiid    = 2'($urandom);
    end
    crc_done = 1'b0;
    settle_checks("frame");
  endtask

  initial begin
    rst = 1'b1; axiiv = 1'b0; axiid = 2'b00; crc_done = 1'b0; crc_ok = 1'b0;

    //            mac                 ndib crc_d ok   fwd  kind      lat junk
    vec[0]  = '{MY_MAC,             288, 3, 1'b1, 288, K_COMMIT, 4,  0};
    vec[1]  = '{48'h112233445566,   288, 3, 1'b1, 24,  K_DROP,   1,  0};
    vec[2]  = '{BCAST,              160, 0, 1'b1, 160, K_DROP,   1,  0};
    vec[3]  = '{BCAST,              258, 0, 1'b1, 258, K_DROP,   1,  0};
    vec[4]  = '{MY_MAC,             256, 0, 1'b1, 256, K_DROP,   9,  0};
    vec[5]  = '{BCAST,              256, 2, 1'b0, 256, K_DROP,   3,  0};
    vec[6]  = '{MY_MAC,             10,  0, 1'b1, 10,  K_DROP,   1,  0};
    vec[7]  = '{BCAST,              256, 8, 1'b1, 256, K_COMMIT, 9,  0};
    vec[8]  = '{MY_MAC,             252, 1, 1'b1, 252, K_DROP,   1,  0};
    vec[9]  = '{48'h69695A065490,   256, 1, 1'b1, 24,  K_DROP,   1,  0};
    vec[10] = '{MY_MAC,             256, 3, 1'b1, 256, K_COMMIT, 4,  30};
    good    = '{MY_MAC,             256, 1, 1'b1, 256, K_COMMIT, 2,  0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_axiov", axiov, 0);
    chk("rst_axiod", axiod, 0);
    chk("rst_commit", commit, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_drop_count", drop_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);

    for (int v = 0; v < 11; v++) run_frame(vec[v]);

    // Reset asserted at dibit 100 of a good frame; the tail must be ignored.
    for (int i = 0; i < 288; i++) begin
      @(posedge clk); #1;
      axiiv = 1'b1;
      axiid = (i < 24) ? MY_MAC[47-2*i -: 2] : 2'($urandom);
      rst   = (i == 100);
      if (i < 100) fwd_q.push_back('{axiid, cyc + 1});
      if (i == 100) begin exp_fc = 0; exp_dc = 0; end
      if (i == 150) begin
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_axiov", axiov, 0);
        chk("midrst_frame_count", frame_count, 0);
      end
    end
    @(posedge clk); #1;
    axiiv = 1'b0;
    repeat (40) @(posedge clk);
    settle_checks("midrst");

    run_frame(vec[0]);

    for (int n = 0; n < 18; n++) run_frame(good);
    @(negedge clk);
    chk("sat_frame_count", frame_count, stat(CNT_SAT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
- Per-frame sequencer between the RMII receive path (ether → bitorder) and the downstream frame buffer/aggregator.
- Tracks each frame's dibit stream, captures and filters the destination MAC, and enforces minimum length and byte alignment.
- Waits for the checksum unit's verdict, then issues exactly one commit or drop pulse per frame and keeps frame statistics.
- Runs on the 50 MHz eth_refclk domain.

Parameters:
- MY_MAC, 48'h69_69_5A_06_54_91, unicast address accepted besides broadcast.
- MIN_BYTES, 64, minimum accepted frame length in bytes (dest MAC through FCS, preamble/SFD already stripped).
- CRC_TIMEOUT, 8, cycles to wait in WAIT_CRC for crc_done before forcing a drop.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  eth_refclk, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- axiiv  in  1  input dibit valid; one frame = one contiguous high run.
- axiid  in  2  input dibit, byte-MSB-first order.
- crc_done  in  1  one-cycle pulse from the checksum unit after the frame ends.
- crc_ok  in  1  checksum verdict, sampled only with crc_done.
- axiov  out  1  forwarded dibit valid.
- axiod  out  2  forwarded dibit.
- commit  out  1  one-cycle pulse: keep the buffered frame.
- drop  out  1  one-cycle pulse: discard the buffered frame.
- busy  out  1  high whenever state != IDLE.
- frame_count  out  CNT_W  committed frames.
- drop_count  out  CNT_W  dropped frames.

Behaviour:
- Reset: all outputs 0, state IDLE, dibit counter 0.
  - Internal prev_valid resets to 1, so a frame already in flight during reset is ignored until axiiv goes low.
- States: IDLE, HDR, PASS, DISCARD, WAIT_CRC, DONE.
- IDLE → HDR only on an axiiv rising edge (axiiv=1, prev_valid=0). The first dibit is counted and forwarded.
- HDR:
  - Shifts 24 dibits MSB-first into a 48-bit dest register.
  - On the cycle the 24th dibit is accepted, compares dest against MY_MAC and 48'hFFFF_FFFF_FFFF. Match → PASS; mismatch → DISCARD.
- Forwarding:
  - axiov/axiod are registered copies of axiiv/axiid: 1-cycle latency, asserted only for dibits accepted in HDR or PASS.
  - Forwarding stops from the first dibit after a filter mismatch.
- Dibit counter: 13 bits, saturating at 8191. Byte length = count>>2.
- End of frame (axiiv 1→0):
  - In HDR → DONE with drop (runt).
  - In PASS:
    - count[1:0] != 0 → drop (misaligned).
    - Length < MIN_BYTES → drop.
    - Otherwise → WAIT_CRC.
  - In DISCARD → DONE with drop.
- WAIT_CRC:
  - crc_done & crc_ok → DONE with commit.
  - crc_done & !crc_ok → drop.
  - Timer reaches CRC_TIMEOUT with no crc_done → drop.
  - crc_done arriving in any other state is ignored.
- DONE:
  - Exactly one cycle. The registered commit or drop pulse is high in this cycle, then → IDLE.
  - Pulse timing: one cycle after the deciding event (the axiiv falling edge or crc_done).
  - commit and drop are never high together.
- axiiv high during WAIT_CRC or DONE: dibits are neither forwarded nor counted. A new frame starts only on a later rising edge seen in IDLE; a frame still in progress is skipped whole.
- Counters:
  - frame_count +1 on commit, drop_count +1 on drop.
  - Both saturate at all-ones; no wrap.
- rst mid-frame: immediate return to IDLE, no commit or drop pulse issued for that frame.

Optional Feature:
- RX_STATS_EN defined: frame_count and drop_count are implemented as above.
- Not defined: both ports are tied to 0 and the counter logic is not compiled. All other behaviour is identical.

Decomposition:
- Shared package eth_pkg:
  - state enum rx_state_t.
  - BCAST_MAC constant.
  - DIBITS_PER_BYTE = 4.
  - MAC_DIBITS = 24.
- One sub-module, sat_counter (width-parameterised saturating counter with increment enable), instantiated twice for the statistics counters.

Test Plan:
- 72-byte frame to MY_MAC, crc_done&crc_ok 3 cycles after end → commit once, 288 dibits forwarded with 1-cycle lag, frame_count=1.
- 72-byte frame to 11:22:33:44:55:66 → forwarding stops after dibit 24, drop pulse 1 cycle after axiiv falls, drop_count=1, no commit.
- 40-byte broadcast frame → drop at end (runt). 64-byte broadcast frame with 2 trailing extra dibits → drop (misaligned).
- Valid 64-byte frame, crc_done never arrives → drop pulse at cycle CRC_TIMEOUT+1 after end. Separately, crc_done with crc_ok=0 → drop.
- Assert rst at dibit 100 of a good frame → no pulse, axiov=0; the remainder of that frame is ignored; the next frame commits normally.
- Drive 2^CNT_W+2 good frames (force CNT_W=4: 18 frames) → frame_count holds 15. With RX_STATS_EN undefined, both counters read 0 throughout.
